// File: rtl/post_add_pkg.sv
// Shared widths, OPMODE field positions and mux encodings for the post-adder stage.
package post_add_pkg;

   localparam int unsigned P_W = 48;
   localparam int unsigned M_W = 36;

   localparam logic [1:0] X_ZERO = 2'd0;
   localparam logic [1:0] X_M    = 2'd1;
   localparam logic [1:0] X_P    = 2'd2;
   localparam logic [1:0] X_DAB  = 2'd3;

   localparam logic [1:0] Z_ZERO = 2'd0;
   localparam logic [1:0] Z_PCIN = 2'd1;
   localparam logic [1:0] Z_P    = 2'd2;
   localparam logic [1:0] Z_C    = 2'd3;

   localparam int unsigned OPM_X_LSB = 0;
   localparam int unsigned OPM_Z_LSB = 2;
   localparam int unsigned OPM_CIN   = 5;
   localparam int unsigned OPM_SUB   = 7;

   // Bit P_W of the result is the carry (add) or borrow (subtract).
   function automatic logic [P_W:0] post_add(input logic [P_W-1:0] z, input logic [P_W-1:0] x,
                                             input logic cin, input logic sub);
      logic [P_W:0] xc;
      xc = {1'b0, x} + {{P_W{1'b0}}, cin};
      return sub ? ({1'b0, z} - xc) : ({1'b0, z} + xc);
   endfunction

endpackage

// File: rtl/post_adder_preg_if.sv
// Operand, control and result bundle of the post-adder stage.
// PATDET is present only when POST_ADD_PATDET_EN is defined.
interface post_adder_preg_if;
   import post_add_pkg::*;

   logic [M_W-1:0] min;
   logic [17:0]    a;
   logic [17:0]    b;
   logic [17:0]    d;
   logic [P_W-1:0] c;
   logic [P_W-1:0] pcin;
   logic           carryin;
   logic [7:0]     opmode;
   logic           cec;
   logic           cep;
   logic           ceopmode;
   logic           cecarryin;
   logic [P_W-1:0] p;
   logic [P_W-1:0] pcout;
   logic           carryout;
   logic           carryoutf;
`ifdef POST_ADD_PATDET_EN
   logic           patdet;

   modport master (
      output min, a, b, d, c, pcin, carryin, opmode, cec, cep, ceopmode, cecarryin,
      input  p, pcout, carryout, carryoutf, patdet
   );
   modport slave (
      input  min, a, b, d, c, pcin, carryin, opmode, cec, cep, ceopmode, cecarryin,
      output p, pcout, carryout, carryoutf, patdet
   );
`else
   modport master (
      output min, a, b, d, c, pcin, carryin, opmode, cec, cep, ceopmode, cecarryin,
      input  p, pcout, carryout, carryoutf
   );
   modport slave (
      input  min, a, b, d, c, pcin, carryin, opmode, cec, cep, ceopmode, cecarryin,
      output p, pcout, carryout, carryoutf
   );
`endif

endinterface

// File: rtl/reg_bypass_an.sv
// Optional pipeline register: clock-enabled flop with async active-low clear, or a plain wire.
module reg_bypass_an #(
   parameter int unsigned Width = 1,
   parameter int unsigned Pipe  = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   if (Pipe != 0) begin : g_reg
      logic [Width-1:0] q_d, q_q;

      always_comb q_d = en_i ? d_i : q_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) q_q <= '0;
         else         q_q <= q_d;
      end

      assign q_o = q_q;
   end else begin : g_wire
      logic unused_ctrl;
      assign unused_ctrl = ^{clk_i, rst_ni, en_i};
      assign q_o = d_i;
   end

endmodule

// File: rtl/post_adder_preg.sv
// DSP48A1-style post-adder: OPMODE-selected X/Z operands, add/sub with carry-in, P register.
// Define POST_ADD_PATDET_EN to add the registered PATDET output and PATTERN/MASK parameters.
module post_adder_preg
   import post_add_pkg::*;
#(
   parameter int unsigned CREG       = 1,
   parameter int unsigned PREG       = 1,
   parameter int unsigned OPMODEREG  = 1,
   parameter int unsigned CARRYINREG = 1,
   parameter string       CARRYINSEL = "OPMODE5"
`ifdef POST_ADD_PATDET_EN
   ,
   parameter logic [P_W-1:0] PATTERN = 48'd0,
   parameter logic [P_W-1:0] MASK    = 48'd0
`endif
) (
   input logic              clk_i,
   input logic              rst_ni,
   post_adder_preg_if.slave bus
);

   localparam bit CinFromPort = (CARRYINSEL == "CARRYIN");

   logic [P_W-1:0] c_eff;
   logic [7:0]     opmode_eff;
   logic           cin_src;
   logic           cin_eff;
   logic [P_W-1:0] x_mux;
   logic [P_W-1:0] z_mux;
   logic [P_W:0]   sum;
   logic [P_W-1:0] p_q;
   logic           carryout_q;

   reg_bypass_an #(.Width(P_W), .Pipe(CREG)) u_creg (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (bus.cec),
      .d_i    (bus.c),
      .q_o    (c_eff)
   );

   reg_bypass_an #(.Width(8), .Pipe(OPMODEREG)) u_opmodereg (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (bus.ceopmode),
      .d_i    (bus.opmode),
      .q_o    (opmode_eff)
   );

   // OPMODE5 carry comes from the effective OPMODE, so it trails it by the CYI stage.
   assign cin_src = CinFromPort ? bus.carryin : opmode_eff[OPM_CIN];

   reg_bypass_an #(.Width(1), .Pipe(CARRYINREG)) u_cyireg (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (bus.cecarryin),
      .d_i    (cin_src),
      .q_o    (cin_eff)
   );

   always_comb begin
      x_mux = '0;
      unique case (opmode_eff[OPM_X_LSB +: 2])
         X_ZERO:  x_mux = '0;
         X_M:     x_mux = {{(P_W-M_W){1'b0}}, bus.min};
         X_P:     x_mux = p_q;
         X_DAB:   x_mux = {bus.d[11:0], bus.a, bus.b};
         default: x_mux = '0;
      endcase
   end

   always_comb begin
      z_mux = '0;
      unique case (opmode_eff[OPM_Z_LSB +: 2])
         Z_ZERO:  z_mux = '0;
         Z_PCIN:  z_mux = bus.pcin;
         Z_P:     z_mux = p_q;
         Z_C:     z_mux = c_eff;
         default: z_mux = '0;
      endcase
   end

   assign sum = post_add(z_mux, x_mux, cin_eff, opmode_eff[OPM_SUB]);

`ifdef POST_ADD_PATDET_EN
   localparam int unsigned PRegW = P_W + 2;
   logic             patdet_d;
   logic             patdet_q;
   logic [PRegW-1:0] preg_d;
   logic [PRegW-1:0] preg_q;

   assign patdet_d = &(~(sum[P_W-1:0] ^ PATTERN) | MASK);
   assign preg_d   = {patdet_d, sum};
   assign {patdet_q, carryout_q, p_q} = preg_q;
   assign bus.patdet = patdet_q;
`else
   localparam int unsigned PRegW = P_W + 1;
   logic [PRegW-1:0] preg_d;
   logic [PRegW-1:0] preg_q;

   assign preg_d = sum;
   assign {carryout_q, p_q} = preg_q;
`endif

   reg_bypass_an #(.Width(PRegW), .Pipe(PREG)) u_preg (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (bus.cep),
      .d_i    (preg_d),
      .q_o    (preg_q)
   );

   assign bus.p         = p_q;
   assign bus.pcout     = p_q;
   assign bus.carryout  = carryout_q;
   assign bus.carryoutf = carryout_q;

   logic unused_bits;
   assign unused_bits = ^{opmode_eff[6], opmode_eff[4], bus.d[17:12]};

endmodule

// File: tb/tb_post_adder_preg.sv
// Self-checking bench for post_adder_preg: directed literal scenarios plus randomized traffic
// compared every cycle against a behavioural model. Honours POST_ADD_PATDET_EN.
module tb_post_adder_preg;
   import post_add_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   post_adder_preg_if bus ();

`ifdef POST_ADD_PATDET_EN
   post_adder_preg #(.PATTERN(48'd24), .MASK(48'd0)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );
`else
   post_adder_preg dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );
`endif

   // Behavioural model: state of each stage as seen by the arithmetic.
   logic [47:0] m_p, m_c;
   logic        m_co, m_cyi, m_pd;
   logic [7:0]  m_opm;
   logic [47:0] mx, mz;
   logic [48:0] mr;

   always_comb begin
      mx = 48'd0;
      mz = 48'd0;
      case (m_opm[1:0])
         2'd0: mx = 48'd0;
         2'd1: mx = {12'd0, bus.min};
         2'd2: mx = m_p;
         default: mx = {bus.d[11:0], bus.a, bus.b};
      endcase
      case (m_opm[3:2])
         2'd0: mz = 48'd0;
         2'd1: mz = bus.pcin;
         2'd2: mz = m_p;
         default: mz = m_c;
      endcase
      if (m_opm[7]) mr = {1'b0, mz} - ({1'b0, mx} + 49'(m_cyi));
      else          mr = {1'b0, mz} + {1'b0, mx} + 49'(m_cyi);
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_p <= 48'd0; m_co <= 1'b0; m_pd <= 1'b0;
         m_c <= 48'd0; m_opm <= 8'd0; m_cyi <= 1'b0;
      end else begin
         if (bus.cep) begin
            m_p  <= mr[47:0];
            m_co <= mr[48];
            m_pd <= (mr[47:0] == 48'd24);
         end
         if (bus.cec)       m_c   <= bus.c;
         if (bus.ceopmode)  m_opm <= bus.opmode;
         if (bus.cecarryin) m_cyi <= m_opm[5];
      end
   end

   int          n_pass = 0;
   int          n_tot  = 0;
   logic        run    = 1'b0;
   int          lit_req = 0;
   int          lit_seen = 0;
   logic [47:0] lit_p;
   logic        lit_co;
   logic        lit_pd;

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
   endtask

   // Single compare process, mid-cycle on the falling edge.
   always @(negedge clk) begin
      if (run) begin
         chk("p", bus.p, m_p);
         chk("pcout", bus.pcout, m_p);
         chk("carryout", 48'(bus.carryout), 48'(m_co));
         chk("carryoutf", 48'(bus.carryoutf), 48'(m_co));
`ifdef POST_ADD_PATDET_EN
         chk("patdet", 48'(bus.patdet), 48'(m_pd));
`endif
         if (lit_req != lit_seen) begin
            lit_seen = lit_req;
            chk("lit_p", bus.p, lit_p);
            chk("lit_pcout", bus.pcout, lit_p);
            chk("lit_carryout", 48'(bus.carryout), 48'(lit_co));
            chk("lit_model_p", m_p, lit_p);
`ifdef POST_ADD_PATDET_EN
            chk("lit_patdet", 48'(bus.patdet), 48'(lit_pd));
`endif
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_lit(input logic [47:0] p, input logic co, input logic pd);
      lit_p  = p;
      lit_co = co;
      lit_pd = pd;
      lit_req++;
   endtask

   // Load OPMODE (and C) while P holds, letting the CYI stage catch up too.
   task automatic setup(input logic [7:0] opm);
      bus.opmode = opm;
      bus.cep = 1'b0;
      tick();
      tick();
      bus.cep = 1'b1;
   endtask

   logic [63:0] r64;

   initial begin
      bus.min = '0; bus.a = '0; bus.b = '0; bus.d = '0; bus.c = '0; bus.pcin = '0;
      bus.carryin = 1'b0; bus.opmode = 8'd0;
      bus.cec = 1'b1; bus.cep = 1'b0; bus.ceopmode = 1'b1; bus.cecarryin = 1'b1;
      rst_n = 1'b0;
      repeat (3) tick();
      run = 1'b1;
      rst_n = 1'b1;

      // Reset while P is non-zero: clears before the next edge and stays clear.
      bus.min = 36'h1234;
      setup(8'h01);
      tick();
      expect_lit(48'h1234, 1'b0, 1'b0);
      tick();
      rst_n = 1'b0;
      expect_lit(48'd0, 1'b0, 1'b0);
      tick();
      expect_lit(48'd0, 1'b0, 1'b0);

      // Accumulate MIN into P.
      bus.min = 36'd6;
      bus.opmode = 8'h09;
      bus.cep = 1'b0;
      rst_n = 1'b1;
      tick();
      bus.cep = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         expect_lit(48'(6 * i), 1'b0, (i == 4));
      end

      // Subtract with OPMODE5 carry-in, without and with borrow.
      bus.c = 48'd100;
      bus.min = 36'd30;
      setup(8'hAD);
      tick();
      expect_lit(48'd69, 1'b0, 1'b0);
      bus.c = 48'd10;
      setup(8'hAD);
      tick();
      expect_lit(48'hFFFF_FFFF_FFEB, 1'b1, 1'b0);

      // Fill P with ones through the concatenation, then wrap by one.
      bus.d = 18'h00FFF; bus.a = 18'h3FFFF; bus.b = 18'h3FFFF;
      setup(8'h03);
      tick();
      expect_lit(48'hFFFF_FFFF_FFFF, 1'b0, 1'b0);
      bus.min = 36'd1;
      setup(8'h09);
      tick();
      expect_lit(48'd0, 1'b1, 1'b0);

      // Concatenation, then hold with CEP low.
      bus.d = 18'h00ABC; bus.a = 18'd1; bus.b = 18'd2;
      setup(8'h03);
      tick();
      expect_lit({12'hABC, 18'd1, 18'd2}, 1'b0, 1'b0);
      bus.cep = 1'b0;
      bus.min = 36'd777;
      tick();
      expect_lit({12'hABC, 18'd1, 18'd2}, 1'b0, 1'b0);
      bus.min = 36'd5;
      bus.d = 18'h00123;
      tick();
      expect_lit({12'hABC, 18'd1, 18'd2}, 1'b0, 1'b0);

      // Randomized traffic with occasional mid-run resets.
      for (int i = 0; i < 400; i++) begin
         bus.min = 36'($urandom) ^ {$urandom_range(0, 15), 32'd0};
         bus.a = 18'($urandom);
         bus.b = 18'($urandom);
         bus.d = 18'($urandom);
         r64 = {$urandom, $urandom};
         bus.c = r64[47:0];
         r64 = {$urandom, $urandom};
         bus.pcin = r64[47:0];
         bus.carryin = 1'($urandom);
         bus.opmode = 8'($urandom);
         bus.cec = ($urandom_range(0, 7) != 0);
         bus.cep = ($urandom_range(0, 7) != 0);
         bus.ceopmode = ($urandom_range(0, 7) != 0);
         bus.cecarryin = ($urandom_range(0, 7) != 0);
         rst_n = ($urandom_range(0, 39) != 0);
         tick();
      end
      rst_n = 1'b1;
      tick();
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
